// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer writer: the writer FSM state encoding
// and the default geometry (RAM address width, symbol width, input byte width).
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_ADDR_WIDTH = 12;
    localparam int FB_SYM_WIDTH  = 2;
    localparam int FB_BYTE_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } fb_state_e;

endpackage

// File: rtl/framebuffer_writer.sv
// -----------------------------------------------------------------------------
// framebuffer_writer
// Accepts pixel bytes and writes them, MSB symbol first, into a narrow RAM
// port A (one symbol per cycle, one address per symbol). Addresses advance
// linearly and wrap at the end of the frame, where frame_done pulses once.
//
// Ports
//   clk               single clock, rising edge
//   reset             synchronous, active-high
//   byte_data/valid   incoming byte, accepted when byte_valid && byte_ready
//   byte_ready        high only while idle
//   frame_start       one-cycle pulse: next write goes to address 0
//   ram_a_*           registered RAM port-A address / data / write / clock enable
//   frame_done        one-cycle pulse after the write to the last address
//   frame_checksum    (only with FB_WRITER_CHECKSUM_EN) XOR of the frame's bytes,
//                     updated in the frame_done cycle
//
// Build option: define FB_WRITER_CHECKSUM_EN to add the frame_checksum output
// and its accumulator; without it neither exists.
// -----------------------------------------------------------------------------
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int SYM_WIDTH  = FB_SYM_WIDTH,
    parameter int BYTE_WIDTH = FB_BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  frame_start,
    output logic [ADDR_WIDTH-1:0] ram_a_address,
    output logic [SYM_WIDTH-1:0]  ram_a_data_in,
    output logic                  ram_a_wr,
    output logic                  ram_a_clk_enable,
`ifdef FB_WRITER_CHECKSUM_EN
    output logic                  frame_done,
    output logic [BYTE_WIDTH-1:0] frame_checksum
`else
    output logic                  frame_done
`endif
);

    localparam int SYM_CNT = BYTE_WIDTH / SYM_WIDTH;
    localparam int IDX_W   = (SYM_CNT > 1) ? $clog2(SYM_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_CNT - 1);

    fb_state_e             state_q, state_d;
    logic [IDX_W-1:0]      sym_q, sym_d;
    logic [BYTE_WIDTH-1:0] byte_q, byte_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;  // address of the next byte's first write
    logic [SYM_WIDTH-1:0]  data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  ready_q, ready_d;
    logic                  ce_q, ce_d;
    logic                  done_q, done_d;
    logic                  pending_q, pending_d;    // frame_start seen mid-byte
    logic                  accept;
    logic                  wrap;

    // Symbol k of a byte, counted from the MSB end.
    function automatic logic [SYM_WIDTH-1:0] sym_of(input logic [BYTE_WIDTH-1:0] b,
                                                    input logic [IDX_W-1:0]      idx);
        logic [BYTE_WIDTH-1:0] sh;
        int                    shamt;
        shamt = int'(idx) * SYM_WIDTH;
        sh    = b << shamt;
        return sh[BYTE_WIDTH-1 -: SYM_WIDTH];
    endfunction

    assign accept = (state_q == ST_IDLE) && byte_valid && ready_q;
    assign wrap   = wr_q && (addr_q == {ADDR_WIDTH{1'b1}});

    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        data_d      = data_q;
        wr_d        = wr_q;
        ready_d     = ready_q;
        pending_d   = pending_q;
        ce_d        = 1'b1;
        done_d      = wrap;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (frame_start) begin
                    next_addr_d = '0;
                    pending_d   = 1'b0;
                end
                if (accept) begin
                    byte_d  = byte_data;
                    state_d = ST_WRITE;
                    ready_d = 1'b0;
                    wr_d    = 1'b1;
                    sym_d   = '0;
                    data_d  = sym_of(byte_data, '0);
                    addr_d  = frame_start ? '0 : next_addr_q;
                end
            end
            ST_WRITE: begin
                if (frame_start) begin
                    pending_d = 1'b1;
                end
                if (sym_q == LAST_IDX) begin
                    // Byte finished: a restart requested during it takes effect now.
                    state_d     = ST_IDLE;
                    wr_d        = 1'b0;
                    ready_d     = 1'b1;
                    next_addr_d = (pending_q || frame_start) ? '0 : addr_q + 1'b1;
                    pending_d   = 1'b0;
                end else begin
                    sym_d  = sym_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                    data_d = sym_of(byte_q, sym_q + 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sym_q       <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b0;
            ce_q        <= 1'b0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            ready_q     <= ready_d;
            ce_q        <= ce_d;
            done_q      <= done_d;
            pending_q   <= pending_d;
        end
    end

    // Latched byte only matters while writing, so it needs no reset.
    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

    assign byte_ready       = ready_q;
    assign ram_a_address    = addr_q;
    assign ram_a_data_in    = data_q;
    assign ram_a_wr         = wr_q;
    assign ram_a_clk_enable = ce_q;
    assign frame_done       = done_q;

`ifdef FB_WRITER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] acc_q, acc_d;
    logic [BYTE_WIDTH-1:0] sum_q, sum_d;
    logic [BYTE_WIDTH-1:0] acc_base;

    // A wrap or restart begins a new frame; a byte accepted in that same
    // cycle is the first byte of the new frame.
    always_comb begin
        acc_base = (wrap || frame_start) ? '0 : acc_q;
        acc_d    = accept ? (acc_base ^ byte_data) : acc_base;
        sum_d    = wrap ? acc_q : sum_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign frame_checksum = sum_q;
`endif

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;

    localparam int AW = 12;
    localparam int SW = 2;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          frame_start;
    logic [AW-1:0] ram_a_address;
    logic [SW-1:0] ram_a_data_in;
    logic          ram_a_wr;
    logic          ram_a_clk_enable;
    logic          frame_done;
`ifdef FB_WRITER_CHECKSUM_EN
    logic [BW-1:0] frame_checksum;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    framebuffer_writer #(
        .ADDR_WIDTH(AW),
        .SYM_WIDTH (SW),
        .BYTE_WIDTH(BW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .frame_start     (frame_start),
        .ram_a_address   (ram_a_address),
        .ram_a_data_in   (ram_a_data_in),
        .ram_a_wr        (ram_a_wr),
        .ram_a_clk_enable(ram_a_clk_enable),
`ifdef FB_WRITER_CHECKSUM_EN
        .frame_done      (frame_done),
        .frame_checksum  (frame_checksum)
`else
        .frame_done      (frame_done)
`endif
    );

    // One row: inputs driven for a cycle, outputs expected right after that edge.
    typedef struct {
        logic          rst;
        logic          vld;
        logic          fs;
        logic [BW-1:0] din;
        logic          rdy;
        logic          wr;
        logic [AW-1:0] addr;
        logic [SW-1:0] dat;
        logic          done;
        logic          ce;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic vld, input logic fs, input logic [BW-1:0] din,
                       input logic rdy, input logic wr, input logic [AW-1:0] addr,
                       input logic [SW-1:0] dat, input logic done, input logic ce);
        vec_t v;
        v.rst = rst; v.vld = vld; v.fs = fs; v.din = din;
        v.rdy = rdy; v.wr = wr; v.addr = addr; v.dat = dat; v.done = done; v.ce = ce;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [17:0] act, exp;
        reset = 1'b1; byte_valid = 1'b0; byte_data = '0; frame_start = 1'b0;

        //   rst vld fs  din     rdy wr addr d  done ce
        add(1, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0);  // reset state
        add(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 1);  // ready the cycle after release
        add(0, 1, 0, 8'hB4,  0, 1, 0, 2, 0, 1);  // 0xB4 -> 2,3,1,0
        add(0, 0, 0, 8'h00,  0, 1, 1, 3, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 2, 1, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 3, 0, 0, 1);
        add(0, 0, 0, 8'h00,  1, 0, 3, 0, 0, 1);  // idle, outputs held
        add(0, 1, 0, 8'h00,  0, 1, 4, 0, 0, 1);  // second byte 0x00
        add(0, 0, 0, 8'h00,  0, 1, 5, 0, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 6, 0, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 7, 0, 0, 1);
        add(0, 0, 0, 8'h00,  1, 0, 7, 0, 0, 1);
        add(0, 0, 1, 8'h00,  1, 0, 7, 0, 0, 1);  // frame_start idle: address held
        add(0, 1, 0, 8'h1B,  0, 1, 0, 0, 0, 1);  // 0x1B at addr 0 -> 0,1,2,3
        add(0, 0, 0, 8'h00,  0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 2, 2, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 3, 3, 0, 1);
        add(0, 0, 0, 8'h00,  1, 0, 3, 3, 0, 1);
        add(0, 1, 0, 8'hE4,  0, 1, 4, 3, 0, 1);  // 0xE4 -> 3,2,1,0
        add(0, 0, 0, 8'h00,  0, 1, 5, 2, 0, 1);
        add(0, 0, 1, 8'h00,  0, 1, 6, 1, 0, 1);  // frame_start during symbol 1
        add(0, 0, 0, 8'h00,  0, 1, 7, 0, 0, 1);
        add(0, 0, 0, 8'h00,  1, 0, 7, 0, 0, 1);
        add(0, 1, 0, 8'hFF,  0, 1, 0, 3, 0, 1);  // restarted at addr 0, no done
        add(0, 0, 0, 8'h00,  0, 1, 1, 3, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 2, 3, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 3, 3, 0, 1);
        add(0, 0, 0, 8'h00,  1, 0, 3, 3, 0, 1);
        add(0, 1, 1, 8'h1B,  0, 1, 0, 0, 0, 1);  // frame_start with accept
        add(0, 0, 0, 8'h00,  0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 2, 2, 0, 1);
        add(1, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0);  // reset during symbol 2
        add(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 8'hB4,  0, 1, 0, 2, 0, 1);  // restarts at addr 0
        add(0, 0, 0, 8'h00,  0, 1, 1, 3, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 2, 1, 0, 1);
        add(0, 0, 0, 8'h00,  0, 1, 3, 0, 0, 1);
        add(0, 0, 0, 8'h00,  1, 0, 3, 0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            reset       = vq[i].rst;
            byte_valid  = vq[i].vld;
            frame_start = vq[i].fs;
            byte_data   = vq[i].din;
            @(posedge clk); #1;
            act = {byte_ready, ram_a_wr, ram_a_address, ram_a_data_in, frame_done, ram_a_clk_enable};
            exp = {vq[i].rdy, vq[i].wr, vq[i].addr, vq[i].dat, vq[i].done, vq[i].ce};
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                $display("FAIL vec%0d: got rdy=%b wr=%b addr=%0d d=%0d done=%b ce=%b, expected rdy=%b wr=%b addr=%0d d=%0d done=%b ce=%b",
                         i, byte_ready, ram_a_wr, ram_a_address, ram_a_data_in, frame_done, ram_a_clk_enable,
                         vq[i].rdy, vq[i].wr, vq[i].addr, vq[i].dat, vq[i].done, vq[i].ce);
            end
        end
        frame_start = 1'b0;

        // Full frame of 0xFF with byte_valid held high.
        begin
            int   exp_addr  = 0;
            int   writes    = 0;
            int   bad       = 0;
            int   dones     = 0;
            logic prev_last = 1'b0;
            logic [AW-1:0] wrap_addr = '1;
            reset = 1'b1; byte_valid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0; byte_valid = 1'b1; byte_data = 8'hFF;
            for (int c = 0; c < 6000 && writes < 4097; c++) begin
                @(posedge clk); #1;
                if (frame_done !== prev_last) bad++;
                if (frame_done) dones++;
                prev_last = ram_a_wr && (ram_a_address == 12'hFFF);
                if (ram_a_wr) begin
                    if (writes < 4096) begin
                        if (ram_a_address !== exp_addr[AW-1:0] || ram_a_data_in !== 2'b11) bad++;
                    end else begin
                        wrap_addr = ram_a_address;
                    end
                    writes++;
                    exp_addr++;
                end
            end
            byte_valid = 1'b0;
            check("frame_write_count", writes, 4097);
            check("frame_addr_data_done_errors", bad, 0);
            check("frame_done_pulses", dones, 1);
            check("addr_after_wrap", wrap_addr, 0);
        end

`ifdef FB_WRITER_CHECKSUM_EN
        // Frame of 1023 x 0x00 followed by 0x5A.
        begin
            int   accepted = 0;
            logic got_done = 1'b0;
            reset = 1'b1; byte_valid = 1'b0;
            @(posedge clk); #1;
            check("checksum_reset", frame_checksum, 0);
            reset = 1'b0; byte_valid = 1'b1;
            for (int c = 0; c < 6000 && !got_done; c++) begin
                byte_data = (accepted == 1023) ? 8'h5A : 8'h00;
                if (byte_ready) accepted++;
                @(posedge clk); #1;
                if (frame_done) begin
                    got_done = 1'b1;
                    check("checksum_at_done", frame_checksum, 8'h5A);
                end
            end
            byte_valid = 1'b0;
            check("checksum_frame_done_seen", got_done, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
